mem_arbiter: RTL and testbench

Arbitrates the single-ported RAM between the instruction-fetch port and the data-memory port of the pipelined datapath. It sits between the datapath-side request signals (`imemREN`/`imemaddr`, `dmemREN`/`dmemWEN`/`dmemaddr`/`dmemstore`) and the RAM. It sequences one access at a time through a three-state FSM and returns wait/load signals to each requester. Data accesses have priority, and a bounded-starvation counter guarantees instruction fetch progress.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/arb_watchdog.sv | 36 +++
 rtl/mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data RAM arbiter.
package mem_arb_pkg;

  // Arbiter FSM states: idle between accesses, instruction access, data access.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2
  } arb_state_t;

  // Encoding of the grant output (current RAM owner).
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_I    = 2'd1,
    GNT_D    = 2'd2
  } grant_t;

  // Word returned to the owner when an access is forcibly completed.
  localparam logic [31:0] ARB_ERR_WORD = 32'hBAD1_BAD1;

endpackage

// File: rtl/arb_watchdog.sv
// Access watchdog: a down-counter loaded at grant time, cleared at the end of
// the access, flagging expiry when it reaches zero while armed.
// Only instantiated by mem_arbiter when MEM_ARB_TIMEOUT_EN is defined.
module arb_watchdog #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clear,
  output logic             expired
);

  logic [WIDTH-1:0] count_reg;
  logic             armed_reg;

  // Load on grant, count down during the access, disarm on clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
      armed_reg <= 1'b0;
    end else if (clear) begin
      count_reg <= '0;
      armed_reg <= 1'b0;
    end else if (load) begin
      count_reg <= load_value;
      armed_reg <= 1'b1;
    end else if (armed_reg && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign expired = armed_reg && (count_reg == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Single-ported RAM arbiter between instruction fetch and data memory ports.
// Data has priority; a saturating burst counter guarantees fetch progress.
// Optional access watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_BURST_MAX = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ram_ren,
  output logic        ram_wen,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_store,
  input  logic [31:0] ram_load,
  input  logic        ram_ready,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  localparam logic [3:0] BURST_MAX = 4'(DATA_BURST_MAX);

  arb_state_t  state_reg;
  grant_t      grant_reg;
  logic [3:0]  dcount_reg;
  logic        ram_ren_reg;
  logic        ram_wen_reg;
  logic [31:0] ram_addr_reg;
  logic [31:0] ram_store_reg;

  logic d_req;
  logic d_blocked;
  logic start_d;
  logic start_i;
  logic in_access;
  logic access_done;
  logic access_end;

  assign d_req     = dREN | dWEN;
  // Data loses only when fetch is waiting and the burst counter is saturated.
  assign d_blocked = iREN && (dcount_reg == BURST_MAX);
  assign start_d   = (state_reg == IDLE) && d_req && !d_blocked;
  assign start_i   = (state_reg == IDLE) && !start_d && iREN;
  assign in_access = (state_reg == IACC) || (state_reg == DACC);
  assign access_end = in_access && access_done;

`ifdef MEM_ARB_TIMEOUT_EN
  logic expired;
  logic force_done;
  logic timeout_err_reg;

  arb_watchdog #(
    .WIDTH(8)
  ) u_watchdog (
    .clk       (CLK),
    .rst       (RST),
    .load      (start_d | start_i),
    .load_value(8'(TIMEOUT_CYCLES - 1)),
    .clear     (access_end),
    .expired   (expired)
  );

  // A real ram_ready on the expiry cycle wins, so the genuine data is returned.
  assign force_done  = expired && !ram_ready;
  assign access_done = ram_ready | expired;

  // Sticky record that at least one access was forcibly completed.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      timeout_err_reg <= 1'b0;
    end else if (in_access && force_done) begin
      timeout_err_reg <= 1'b1;
    end
  end

  assign timeout_err = timeout_err_reg;
  assign iload       = force_done ? ARB_ERR_WORD : ram_load;
  assign dload       = force_done ? ARB_ERR_WORD : ram_load;
`else
  assign access_done = ram_ready;
  assign timeout_err = 1'b0;
  assign iload       = ram_load;
  assign dload       = ram_load;
`endif

  // Arbitration FSM: grant, latch address/data/type, hold strobes to completion.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg     <= IDLE;
      grant_reg     <= GNT_NONE;
      dcount_reg    <= 4'd0;
      ram_ren_reg   <= 1'b0;
      ram_wen_reg   <= 1'b0;
      ram_addr_reg  <= 32'd0;
      ram_store_reg <= 32'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_d) begin
            state_reg     <= DACC;
            grant_reg     <= GNT_D;
            ram_addr_reg  <= daddr;
            ram_store_reg <= dstore;
            // Write wins when both read and write are requested.
            ram_wen_reg   <= dWEN;
            ram_ren_reg   <= !dWEN;
            if (!iREN) begin
              dcount_reg <= 4'd0;
            end else if (dcount_reg != BURST_MAX) begin
              dcount_reg <= dcount_reg + 4'd1;
            end
          end else if (start_i) begin
            state_reg    <= IACC;
            grant_reg    <= GNT_I;
            ram_addr_reg <= iaddr;
            ram_ren_reg  <= 1'b1;
            ram_wen_reg  <= 1'b0;
            dcount_reg   <= 4'd0;
          end
        end
        IACC, DACC: begin
          // Return to IDLE for one dead cycle so a held request is not re-granted.
          if (access_done) begin
            state_reg   <= IDLE;
            grant_reg   <= GNT_NONE;
            ram_ren_reg <= 1'b0;
            ram_wen_reg <= 1'b0;
          end
        end
        default: begin
          state_reg   <= IDLE;
          grant_reg   <= GNT_NONE;
          ram_ren_reg <= 1'b0;
          ram_wen_reg <= 1'b0;
        end
      endcase
    end
  end

  assign iwait     = iREN & ~((state_reg == IACC) & access_done);
  assign dwait     = d_req & ~((state_reg == DACC) & access_done);
  assign ram_ren   = ram_ren_reg;
  assign ram_wen   = ram_wen_reg;
  assign ram_addr  = ram_addr_reg;
  assign ram_store = ram_store_reg;
  assign grant     = grant_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a simple latency-programmable RAM model.
// The timeout scenario runs only when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ram_ren;
  logic        ram_wen;
  logic [31:0] ram_addr;
  logic [31:0] ram_store;
  logic [31:0] ram_load;
  logic        ram_ready;
  logic [1:0]  grant;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(
    .DATA_BURST_MAX(4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .iREN       (iREN),
    .iaddr      (iaddr),
    .iwait      (iwait),
    .iload      (iload),
    .dREN       (dREN),
    .dWEN       (dWEN),
    .daddr      (daddr),
    .dstore     (dstore),
    .dwait      (dwait),
    .dload      (dload),
    .ram_ren    (ram_ren),
    .ram_wen    (ram_wen),
    .ram_addr   (ram_addr),
    .ram_store  (ram_store),
    .ram_load   (ram_load),
    .ram_ready  (ram_ready),
    .grant      (grant),
    .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  // RAM model: ready after 'lat' strobe cycles, read data = addr ^ A5A50000.
  logic [7:0]  lat = 8'd2;
  logic        stuck = 1'b0;
  logic [7:0]  acc_cnt;
  logic [31:0] wr_addr_seen = 32'd0;
  logic [31:0] wr_data_seen = 32'd0;

  assign ram_ready = !stuck && (ram_ren || ram_wen) && (acc_cnt == lat - 8'd1);
  assign ram_load  = ram_addr ^ 32'hA5A5_0000;

  always @(posedge CLK or posedge RST) begin
    if (RST) acc_cnt <= 8'd0;
    else if (!(ram_ren || ram_wen) || ram_ready) acc_cnt <= 8'd0;
    else acc_cnt <= acc_cnt + 8'd1;
  end

  always @(posedge CLK) begin
    if (ram_wen && ram_ready) begin
      wr_addr_seen <= ram_addr;
      wr_data_seen <= ram_store;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int exp_seq[10];
    int got_seq[$];

    // Reset state; wait outputs follow requests during reset.
    RST = 1'b1; iREN = 1'b1; iaddr = 32'd0; dREN = 1'b0; dWEN = 1'b0;
    daddr = 32'd0; dstore = 32'd0;
    #3;
    check_val("rst_grant", 32'(grant), 32'd0);
    check_val("rst_ren", 32'(ram_ren), 32'd0);
    check_val("rst_wen", 32'(ram_wen), 32'd0);
    check_val("rst_addr", ram_addr, 32'd0);
    check_val("rst_store", ram_store, 32'd0);
    check_val("rst_terr", 32'(timeout_err), 32'd0);
    check_val("rst_iwait", 32'(iwait), 32'd1);
    check_val("rst_dwait", 32'(dwait), 32'd0);
    iREN = 1'b0;
    cyc(); cyc();
    RST = 1'b0;

    // Instruction fetch, latency 2.
    cyc(); iREN = 1'b1; iaddr = 32'h40; lat = 8'd2; #1;
    check_val("i_idle_iwait", 32'(iwait), 32'd1);
    cyc();
    check_val("i_c1_ren", 32'(ram_ren), 32'd1);
    check_val("i_c1_addr", ram_addr, 32'h40);
    check_val("i_c1_grant", 32'(grant), 32'd1);
    check_val("i_c1_iwait", 32'(iwait), 32'd1);
    iaddr = 32'h44; #1;
    cyc();
    check_val("i_c2_ren", 32'(ram_ren), 32'd1);
    check_val("i_c2_addr_held", ram_addr, 32'h40);
    check_val("i_c2_iwait", 32'(iwait), 32'd0);
    check_val("i_c2_iload", iload, 32'hA5A5_0040);
    cyc(); iREN = 1'b0; #1;
    check_val("i_dead_ren", 32'(ram_ren), 32'd0);
    check_val("i_dead_grant", 32'(grant), 32'd0);
    $display("txn instr read addr=00000040 data=%h", iload);

    // Data write, latency 2.
    dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEAD_BEEF; #1;
    cyc();
    check_val("w_wen", 32'(ram_wen), 32'd1);
    check_val("w_ren", 32'(ram_ren), 32'd0);
    check_val("w_store", ram_store, 32'hDEAD_BEEF);
    check_val("w_grant", 32'(grant), 32'd2);
    check_val("w_dwait_c1", 32'(dwait), 32'd1);
    cyc();
    check_val("w_dwait_c2", 32'(dwait), 32'd0);
    cyc(); dWEN = 1'b0; #1;
    check_val("w_wen_off", 32'(ram_wen), 32'd0);
    check_val("w_mem_addr", wr_addr_seen, 32'h100);
    check_val("w_mem_data", wr_data_seen, 32'hDEAD_BEEF);
    $display("txn data write addr=00000100 data=deadbeef");

    // Read+write collision, latency 1: behaves as a write.
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h200; dstore = 32'h1234_5678; lat = 8'd1; #1;
    cyc();
    check_val("rw_wen", 32'(ram_wen), 32'd1);
    check_val("rw_ren", 32'(ram_ren), 32'd0);
    check_val("rw_dwait", 32'(dwait), 32'd0);
    cyc(); dREN = 1'b0; dWEN = 1'b0; #1;
    check_val("rw_mem_data", wr_data_seen, 32'h1234_5678);
    check_val("rw_grant", 32'(grant), 32'd0);
    $display("txn data rd+wr addr=00000200 data=12345678");

    // Data read, latency 3, address change mid-access ignored.
    dREN = 1'b1; daddr = 32'h300; lat = 8'd3; #1;
    cyc();
    check_val("r_ren", 32'(ram_ren), 32'd1);
    check_val("r_dwait_c1", 32'(dwait), 32'd1);
    daddr = 32'h999; #1;
    cyc();
    check_val("r_dwait_c2", 32'(dwait), 32'd1);
    check_val("r_addr_held", ram_addr, 32'h300);
    cyc();
    check_val("r_dwait_c3", 32'(dwait), 32'd0);
    check_val("r_dload", dload, 32'hA5A5_0300);
    cyc(); dREN = 1'b0; #1;
    $display("txn data read addr=00000300 data=a5a50300");

    // Contention with both requests held, latency 1.
    exp_seq = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
    iREN = 1'b1; dREN = 1'b1; iaddr = 32'h20; daddr = 32'h10; lat = 8'd1; #1;
    for (int c = 0; c < 20; c++) begin
      cyc();
      if (grant != 2'd0) got_seq.push_back(int'(grant));
    end
    iREN = 1'b0; dREN = 1'b0;
    check_val("cont_count", 32'(got_seq.size()), 32'd10);
    for (int k = 0; k < 10; k++) begin
      if (k < got_seq.size()) begin
        check_val($sformatf("cont_grant%0d", k), 32'(got_seq[k]), 32'(exp_seq[k]));
        $display("txn contention access %0d grant=%0d", k, got_seq[k]);
      end
    end
    cyc();

    // Reset asserted mid data access.
    stuck = 1'b1; dREN = 1'b1; daddr = 32'h500; #1;
    cyc();
    check_val("mr_ren_before", 32'(ram_ren), 32'd1);
    check_val("mr_grant_before", 32'(grant), 32'd2);
    #2 RST = 1'b1; #1;
    check_val("mr_ren_async", 32'(ram_ren), 32'd0);
    check_val("mr_grant_async", 32'(grant), 32'd0);
    check_val("mr_addr_async", ram_addr, 32'd0);
    check_val("mr_dwait", 32'(dwait), 32'd1);
    dREN = 1'b0; stuck = 1'b0;
    @(negedge CLK); RST = 1'b0;
    cyc();
    check_val("mr_grant_after", 32'(grant), 32'd0);
    check_val("mr_ren_after", 32'(ram_ren), 32'd0);
    $display("txn data read addr=00000500 aborted by reset");

`ifdef MEM_ARB_TIMEOUT_EN
    // Watchdog: RAM never ready, forced completion at access cycle 8.
    stuck = 1'b1; iREN = 1'b1; iaddr = 32'h80; #1;
    cyc();
    repeat (6) cyc();
    check_val("to_c7_iwait", 32'(iwait), 32'd1);
    cyc();
    check_val("to_c8_iwait", 32'(iwait), 32'd0);
    check_val("to_c8_iload", iload, 32'hBAD1_BAD1);
    cyc(); iREN = 1'b0; stuck = 1'b0; #1;
    check_val("to_err_set", 32'(timeout_err), 32'd1);
    check_val("to_ren_off", 32'(ram_ren), 32'd0);
    repeat (3) cyc();
    check_val("to_err_sticky", 32'(timeout_err), 32'd1);
    $display("txn instr read addr=00000080 timed out");
`else
    check_val("terr_tied", 32'(timeout_err), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
